// File: rtl/scs8hd_nand3b_bist_seq.sv
// BIST sequencer for a single nand3b cell: sweeps all {AN,B,C} vectors,
// samples Y after a settle window, and tallies mismatches against the ideal cell.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for START; results of the last run stay readable
// S_SETTLE | current vector held on the cell, settle counter running
// S_SAMPLE | Y compared with expected value, vector advanced
// S_DONE   | one-cycle completion pulse, PASS updated
module scs8hd_nand3b_bist_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic             DUT_AN,
  output logic             DUT_B,
  output logic             DUT_C,
  input  logic             DUT_Y,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic [2:0]       FAIL_VEC,
  output logic             FAIL_VALID
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0]       SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       LAST_PASS     = 4'(PASSES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX       = '1;

  generate
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
      $error("SETTLE_CYCLES out of range 1..255");
    end
    if (PASSES < 1 || PASSES > 15) begin : g_bad_passes
      $error("PASSES out of range 1..15");
    end
    if (ERR_W < 1) begin : g_bad_errw
      $error("ERR_W must be at least 1");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [2:0]       vec, vec_nxt;
  logic [7:0]       settle_cnt, settle_nxt;
  logic [3:0]       pass_cnt, pass_cnt_nxt;
  logic [ERR_W-1:0] err_cnt, err_cnt_nxt;
  logic [2:0]       fail_vec, fail_vec_nxt;
  logic             fail_valid, fail_valid_nxt;
  logic             pass_q, pass_nxt;
  logic             exp_y;
  logic             mismatch;

  // Ideal nand3b response: Y low only when AN=0, B=1, C=1.
  assign exp_y    = ~(~vec[2] & vec[1] & vec[0]);
  assign mismatch = (DUT_Y != exp_y);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    vec_nxt        = vec;
    settle_nxt     = settle_cnt;
    pass_cnt_nxt   = pass_cnt;
    err_cnt_nxt    = err_cnt;
    fail_vec_nxt   = fail_vec;
    fail_valid_nxt = fail_valid;
    pass_nxt       = pass_q;

    case (state)
      S_IDLE: begin
        if (START) begin
          err_cnt_nxt    = '0;
          fail_vec_nxt   = 3'b000;
          fail_valid_nxt = 1'b0;
          pass_nxt       = 1'b0;
          vec_nxt        = 3'b000;
          pass_cnt_nxt   = 4'd0;
          settle_nxt     = SETTLE_RELOAD;
          state_nxt      = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (settle_cnt == 8'd0) begin
          state_nxt = S_SAMPLE;
        end else begin
          settle_nxt = settle_cnt - 8'd1;
        end
      end

      S_SAMPLE: begin
        if (mismatch) begin
          if (err_cnt != ERR_MAX) begin
            err_cnt_nxt = err_cnt + 1'b1;
          end
          if (!fail_valid) begin
            fail_vec_nxt   = vec;
            fail_valid_nxt = 1'b1;
          end
        end
        if (vec != 3'd7) begin
          vec_nxt    = vec + 3'd1;
          settle_nxt = SETTLE_RELOAD;
          state_nxt  = S_SETTLE;
        end else if (pass_cnt != LAST_PASS) begin
          vec_nxt      = 3'd0;
          pass_cnt_nxt = pass_cnt + 4'd1;
          settle_nxt   = SETTLE_RELOAD;
          state_nxt    = S_SETTLE;
        end else begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // err_cnt already includes the final sample, taken one edge earlier.
        pass_nxt  = (err_cnt == '0);
        vec_nxt   = 3'd0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      vec        <= 3'b000;
      settle_cnt <= 8'd0;
      pass_cnt   <= 4'd0;
      err_cnt    <= '0;
      fail_vec   <= 3'b000;
      fail_valid <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      vec        <= vec_nxt;
      settle_cnt <= settle_nxt;
      pass_cnt   <= pass_cnt_nxt;
      err_cnt    <= err_cnt_nxt;
      fail_vec   <= fail_vec_nxt;
      fail_valid <= fail_valid_nxt;
      pass_q     <= pass_nxt;
    end
  end

  assign BUSY       = (state == S_SETTLE) || (state == S_SAMPLE);
  assign DONE       = (state == S_DONE);
  assign PASS       = pass_q;
  assign DUT_AN     = vec[2];
  assign DUT_B      = vec[1];
  assign DUT_C      = vec[0];
  assign ERR_CNT    = err_cnt;
  assign FAIL_VEC   = fail_vec;
  assign FAIL_VALID = fail_valid;

endmodule

// File: tb/tb_scs8hd_nand3b_bist_seq.sv
// Directed bench: three sequencer instances (default, PASSES=3, PASSES=15/ERR_W=4)
// driven against an ideal or stuck-at cell model, checked with immediate assertions.
module tb_scs8hd_nand3b_bist_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // instance A: defaults, cell model selectable (0 good, 1 stuck-at-1, 2 stuck-at-0)
  int         mode_a = 0;
  logic       start_a = 1'b0;
  logic       busy_a, done_a, pass_a, an_a, b_a, c_a, y_a;
  logic [7:0] err_a;
  logic [2:0] fvec_a;
  logic       fvalid_a;
  assign y_a = (mode_a == 0) ? ~(~an_a & b_a & c_a) : (mode_a == 1);

  scs8hd_nand3b_bist_seq u_a (
    .CLK(clk), .RESET(rst), .START(start_a), .BUSY(busy_a), .DONE(done_a),
    .PASS(pass_a), .DUT_AN(an_a), .DUT_B(b_a), .DUT_C(c_a), .DUT_Y(y_a),
    .ERR_CNT(err_a), .FAIL_VEC(fvec_a), .FAIL_VALID(fvalid_a)
  );

  // instance B: PASSES=3, Y stuck-at-0
  logic       start_b = 1'b0;
  logic       busy_b, done_b, pass_b, an_b, b_b, c_b;
  logic       y_b = 1'b0;
  logic [7:0] err_b;
  logic [2:0] fvec_b;
  logic       fvalid_b;

  scs8hd_nand3b_bist_seq #(.SETTLE_CYCLES(2), .PASSES(3), .ERR_W(8)) u_b (
    .CLK(clk), .RESET(rst), .START(start_b), .BUSY(busy_b), .DONE(done_b),
    .PASS(pass_b), .DUT_AN(an_b), .DUT_B(b_b), .DUT_C(c_b), .DUT_Y(y_b),
    .ERR_CNT(err_b), .FAIL_VEC(fvec_b), .FAIL_VALID(fvalid_b)
  );

  // instance C: PASSES=15, ERR_W=4, Y stuck-at-0
  logic       start_c = 1'b0;
  logic       busy_c, done_c, pass_c, an_c, b_c, c_c;
  logic       y_c = 1'b0;
  logic [3:0] err_c;
  logic [2:0] fvec_c;
  logic       fvalid_c;

  scs8hd_nand3b_bist_seq #(.SETTLE_CYCLES(2), .PASSES(15), .ERR_W(4)) u_c (
    .CLK(clk), .RESET(rst), .START(start_c), .BUSY(busy_c), .DONE(done_c),
    .PASS(pass_c), .DUT_AN(an_c), .DUT_B(b_c), .DUT_C(c_c), .DUT_Y(y_c),
    .ERR_CNT(err_c), .FAIL_VEC(fvec_c), .FAIL_VALID(fvalid_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Pulse START on the selected instance and count edges until DONE is seen.
  task automatic run(input int sel, output int lat);
    if (sel == 0) start_a = 1'b1; else if (sel == 1) start_b = 1'b1; else start_c = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    lat = 0;
    while (!sel_done(sel) && lat < 2000) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int done_seen;

    // reset
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_vec", {an_a, b_a, c_a}, 0);
    check("rst_err", err_a, 0);
    check("rst_fvec", fvec_a, 0);
    check("rst_fvalid", fvalid_a, 0);

    // 1: good cell, vector stepping and timing
    mode_a  = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t1_busy0", busy_a, 1);
    check("t1_vec0", {an_a, b_a, c_a}, 0);
    for (int k = 1; k <= 23; k++) begin
      tick();
      check("t1_vec", {an_a, b_a, c_a}, k / 3);
      check("t1_busy", busy_a, 1);
      check("t1_nodone", done_a, 0);
    end
    tick();
    check("t1_done", done_a, 1);
    check("t1_busy_done", busy_a, 0);
    check("t1_vec_done", {an_a, b_a, c_a}, 7);
    check("t1_err", err_a, 0);
    tick();
    check("t1_done_off", done_a, 0);
    check("t1_pass", pass_a, 1);
    check("t1_vec_idle", {an_a, b_a, c_a}, 0);
    check("t1_fvalid", fvalid_a, 0);

    // 2: Y stuck-at-1 -> only 011 fails
    mode_a = 1;
    run(0, lat);
    check("t2_lat", lat, 24);
    check("t2_err", err_a, 1);
    check("t2_fvec", fvec_a, 3);
    check("t2_fvalid", fvalid_a, 1);
    tick();
    check("t2_pass", pass_a, 0);
    check("t2_err_idle", err_a, 1);

    // 6: START re-pulsed while busy, then held through DONE
    mode_a  = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 2000) begin
      start_a = (lat == 5 || lat == 12);
      tick();
      lat++;
    end
    check("t6_lat_repulse", lat, 24);
    start_a = 1'b1;
    tick();
    check("t6_idle_done", done_a, 0);
    check("t6_idle_busy", busy_a, 0);
    check("t6_idle_pass", pass_a, 1);
    tick();
    check("t6_restart_busy", busy_a, 1);
    check("t6_restart_pass", pass_a, 0);
    start_a = 1'b0;
    lat = 0;
    while (!done_a && lat < 2000) begin
      tick();
      lat++;
    end
    check("t6_lat_second", lat, 24);
    tick();
    check("t6_pass_second", pass_a, 1);

    // 5: reset mid-run with Y stuck-at-0
    mode_a  = 2;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    check("t5_err_pre", err_a, 3);
    check("t5_fvalid_pre", fvalid_a, 1);
    check("t5_busy_pre", busy_a, 1);
    rst = 1'b1;
    tick();
    check("t5_busy", busy_a, 0);
    check("t5_vec", {an_a, b_a, c_a}, 0);
    check("t5_err", err_a, 0);
    check("t5_fvalid", fvalid_a, 0);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_a) done_seen++;
    end
    check("t5_no_done", done_seen, 0);
    check("t5_busy_after", busy_a, 0);

    // 3: PASSES=3, stuck-at-0
    run(1, lat);
    check("t3_lat", lat, 72);
    check("t3_err", err_b, 21);
    check("t3_fvec", fvec_b, 0);
    check("t3_fvalid", fvalid_b, 1);
    tick();
    check("t3_pass", pass_b, 0);

    // 4: PASSES=15, ERR_W=4 saturation
    run(2, lat);
    check("t4_lat", lat, 360);
    check("t4_err_sat", err_c, 15);
    check("t4_fvec", fvec_c, 0);
    tick();
    check("t4_pass", pass_c, 0);
    check("t4_err_idle", err_c, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
